// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch types -- FSM states, NOP encoding and queue entry layout.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_queue.sv
// fetch_queue: sync FIFO of fetch entries; ports clk, rst_n, push/din, pop/dout (head), flush, count, full, empty.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] head, tail;
  fetch_entry_t  mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[tail] <= din;
  assign dout  = mem[head];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer; owns fetch PC, prefetch queue, stalls and redirects.
// Ports: clk, rst_n (async low); imem_req/imem_addr/imem_rdata to instruction memory;
// id_ready from decode; redirect_valid/redirect_pc from EX; if_valid/if_instr/if_pc/fq_count to decode.
// Build option IMEM_SYNC_READ_EN: memory returns data one cycle after issue (adds inflight + FLUSH).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4,
  localparam int         CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          id_ready,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          if_valid,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc,
  output logic [CW-1:0] fq_count
);
  fetch_state_t state;
  logic [31:0]  fetch_pc, target;
  logic         inflight, room, issue, push, pop, full, empty;
  fetch_entry_t din, dout;
`ifdef IMEM_SYNC_READ_EN
  logic [31:0] inflight_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= issue;
      inflight_pc <= fetch_pc;
    end
  // The outstanding read reserves a slot so its returning word always fits.
  assign room = !full && !(inflight && fq_count == CW'(FQ_DEPTH - 1));
  assign push = inflight && state == RUN && !redirect_valid;
  assign din  = '{pc: inflight_pc, instr: imem_rdata};
`else
  assign inflight = 1'b0;
  assign room     = !full;
  assign push     = issue;
  assign din      = '{pc: fetch_pc, instr: imem_rdata};
`endif
  // Issue looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign issue     = state == RUN && room && !redirect_valid;
  assign pop       = if_valid && id_ready && !redirect_valid;
  assign target    = redirect_pc & ~32'h3;
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign if_valid  = !empty;
  assign if_instr  = if_valid ? dout.instr : NOP_INSTR;
  assign if_pc     = if_valid ? dout.pc : 32'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= (redirect_valid && inflight && state == RUN) ? FLUSH : RUN;
      fetch_pc <= redirect_valid ? target : issue ? fetch_pc + 32'd4 : fetch_pc;
    end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (dout),
    .count (fq_count),
    .full  (full),
    .empty (empty)
  );
endmodule
